// File: rtl/intr_ctrl.sv
// intr_ctrl: edge-latched, masked, fixed-priority interrupt controller with in-service hold until EOI
module intr_ctrl #(
    parameter int NSRC = 8
) (
    input  logic            Clock,
    input  logic            Resetn,
    input  logic [NSRC-1:0] irq,
    output logic            intr,
    input  logic            inta,
    input  logic            io_sel,
    input  logic [3:0]      io_addr,
    input  logic            io_we,
    input  logic [31:0]     io_wdata,
    output logic [31:0]     io_rdata
);
    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;
    state_t          state, state_next;
    logic [NSRC-1:0] pend, mask, irq_q, req, rise, w1c, ack_clr;
    logic [2:0]      id, act_id;
    logic [31:0]     cause;
    logic            wr, wr_pend, wr_mask, wr_eoi, ack;
    logic            unused;
    assign unused  = ^{io_addr[1:0], io_wdata[31:NSRC]};
    assign wr      = io_sel & io_we;
    assign wr_pend = wr && io_addr[3:2] == 2'd0;
    assign wr_mask = wr && io_addr[3:2] == 2'd1;
    assign wr_eoi  = wr && io_addr[3:2] == 2'd3;
    assign req     = pend & mask;
    assign rise    = irq & ~irq_q;
    assign w1c     = wr_pend ? io_wdata[NSRC-1:0] : '0;
    assign ack     = state == REQ && inta;
    assign ack_clr = ack ? NSRC'(1) << id : '0;
    always_comb begin
        id = '0;
        for (int i = NSRC - 1; i >= 0; i--)
            if (req[i]) id = 3'(i);
    end
    always_comb begin
        state_next = state;
        state_next = state == IDLE ? (|req ? REQ : IDLE)
                   : state == REQ  ? (inta ? SERVICE : (|req ? REQ : IDLE))
                   : (wr_eoi ? IDLE : SERVICE);
    end
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state  <= IDLE;
            pend   <= '0;
            mask   <= '0;
            act_id <= '0;
            irq_q  <= irq;
            intr   <= 1'b0;
        end else begin
            state  <= state_next;
            pend   <= (pend & ~w1c & ~ack_clr) | rise;
            mask   <= wr_mask ? io_wdata[NSRC-1:0] : mask;
            act_id <= ack ? id : act_id;
            irq_q  <= irq;
            intr   <= state_next == REQ;
        end
    end
    always_comb begin
        cause    = state == REQ     ? {1'b1, 28'b0, id}
                 : state == SERVICE ? {1'b1, 28'b0, act_id} : '0;
        io_rdata = !io_sel                 ? '0
                 : io_addr[3:2] == 2'd0    ? 32'(pend)
                 : io_addr[3:2] == 2'd1    ? 32'(mask)
                 : io_addr[3:2] == 2'd2    ? cause : '0;
    end
endmodule

// File: tb/tb_intr_ctrl.sv
// tb_intr_ctrl: directed scenarios plus random traffic against a behavioural controller model
module tb_intr_ctrl;
    logic        Clock = 0, Resetn = 0, intr, inta = 0, io_sel = 0, io_we = 0;
    logic [7:0]  irq = 0;
    logic [3:0]  io_addr = 0;
    logic [31:0] io_wdata = 0, io_rdata;
    int          errors = 0, checks = 0;
    // model: mode 0 = idle, 1 = requesting, 2 = in service
    int          m_mode = 0;
    logic [7:0]  m_pend = 0, m_mask = 0, m_prev = 0;
    logic [2:0]  m_act = 0;
    logic        m_intr = 0;

    intr_ctrl #(.NSRC(8)) dut (
        .Clock(Clock), .Resetn(Resetn), .irq(irq), .intr(intr), .inta(inta),
        .io_sel(io_sel), .io_addr(io_addr), .io_we(io_we), .io_wdata(io_wdata), .io_rdata(io_rdata)
    );

    always #5 Clock = ~Clock;

    function automatic logic [2:0] lowest(input logic [7:0] v);
        for (int i = 0; i < 8; i++) if (v[i]) return 3'(i);
        return 3'd0;
    endfunction

    function automatic logic [31:0] exp_rdata();
        logic [7:0] r = m_pend & m_mask;
        if (!io_sel) return 0;
        case (io_addr[3:2])
            2'd0: return {24'b0, m_pend};
            2'd1: return {24'b0, m_mask};
            2'd2: return m_mode == 1 ? {1'b1, 28'b0, lowest(r)} : m_mode == 2 ? {1'b1, 28'b0, m_act} : 0;
            default: return 0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cycle();
        logic [7:0] r, w1c, ackclr, p;
        logic [1:0] a;
        logic eoi;
        int nmode;
        r      = m_pend & m_mask;
        a      = io_addr[3:2];
        w1c    = (io_sel && io_we && a == 0) ? io_wdata[7:0] : 8'h00;
        eoi    = io_sel && io_we && a == 3;
        ackclr = (m_mode == 1 && inta) ? 8'h01 << lowest(r) : 8'h00;
        p      = irq;
        @(posedge Clock);
        #1;
        if (!Resetn) begin
            m_mode = 0; m_pend = 0; m_mask = 0; m_act = 0;
        end else begin
            if (m_mode == 1 && inta) m_act = lowest(r);
            m_pend = (m_pend & ~w1c & ~ackclr) | (p & ~m_prev);
            if (io_sel && io_we && a == 1) m_mask = io_wdata[7:0];
            nmode = m_mode == 0 ? (r != 0 ? 1 : 0)
                  : m_mode == 1 ? (inta ? 2 : (r != 0 ? 1 : 0))
                  : (eoi ? 0 : 2);
            m_mode = nmode;
        end
        m_prev = p;
        m_intr = m_mode == 1;
        chk("intr", {31'b0, intr}, {31'b0, m_intr});
        chk("rdata", io_rdata, exp_rdata());
    endtask

    task automatic quiet();
        io_sel = 0; io_we = 0; inta = 0; io_addr = 0; io_wdata = 0;
    endtask

    task automatic wr(input logic [3:0] addr, input logic [31:0] data);
        io_sel = 1; io_we = 1; io_addr = addr; io_wdata = data;
        cycle();
        quiet();
    endtask

    task automatic rd(input logic [3:0] addr, output logic [31:0] data);
        io_sel = 1; io_we = 0; io_addr = addr;
        #1;
        data = io_rdata;
        io_sel = 0;
    endtask

    task automatic ack();
        inta = 1;
        cycle();
        inta = 0;
    endtask

    initial begin
        logic [31:0] d;
        // reset with all sources high: no edges must appear after release
        irq = 8'hFF; Resetn = 0;
        cycle(); cycle();
        Resetn = 1;
        cycle(); cycle();
        chk("rst_intr", {31'b0, intr}, 32'h0);
        rd(4'h0, d); chk("rst_pend", d, 32'h0);
        rd(4'h8, d); chk("rst_cause", d, 32'h0);
        irq = 0; cycle();
        // single source
        wr(4'h4, 32'h04);
        irq = 8'h04; cycle(); irq = 0; cycle();
        chk("single_intr", {31'b0, intr}, 32'h1);
        rd(4'h8, d); chk("single_cause", d, 32'h8000_0002);
        ack();
        chk("single_ack_intr", {31'b0, intr}, 32'h0);
        rd(4'h0, d); chk("single_ack_pend", d, 32'h0);
        rd(4'h8, d); chk("single_frozen", d, 32'h8000_0002);
        wr(4'hC, 32'h0);
        rd(4'h8, d); chk("single_eoi_cause", d, 32'h0);
        // priority
        wr(4'h4, 32'hFF);
        irq = 8'h22; cycle(); irq = 0; cycle();
        rd(4'h8, d); chk("prio_first", d, 32'h8000_0001);
        ack();
        wr(4'hC, 32'h0);
        cycle();
        chk("prio_intr2", {31'b0, intr}, 32'h1);
        rd(4'h8, d); chk("prio_second", d, 32'h8000_0005);
        ack(); wr(4'hC, 32'h0); cycle();
        // masking
        wr(4'h4, 32'h00);
        irq = 8'h08; cycle(); irq = 0; cycle(); cycle();
        chk("mask_intr0", {31'b0, intr}, 32'h0);
        rd(4'h0, d); chk("mask_pend", d, 32'h08);
        wr(4'h4, 32'h08);
        cycle();
        chk("mask_intr1", {31'b0, intr}, 32'h1);
        wr(4'h4, 32'h00);
        cycle();
        chk("mask_drop", {31'b0, intr}, 32'h0);
        rd(4'h8, d); chk("mask_idle", d, 32'h0);
        wr(4'h0, 32'h08);
        // set/clear race
        irq = 8'h01; io_sel = 1; io_we = 1; io_addr = 4'h0; io_wdata = 32'h01;
        cycle(); quiet();
        rd(4'h0, d); chk("race_pend", d, 32'h01);
        irq = 0; cycle(); wr(4'h0, 32'h01);
        // no nesting
        wr(4'h4, 32'hFF);
        irq = 8'h10; cycle(); irq = 0; cycle();
        ack();
        rd(4'h8, d); chk("nest_cause", d, 32'h8000_0004);
        irq = 8'h01; cycle(); irq = 0; cycle(); cycle();
        chk("nest_intr", {31'b0, intr}, 32'h0);
        rd(4'h0, d); chk("nest_pend", d, 32'h01);
        wr(4'hC, 32'h0);
        cycle();
        chk("nest_after_eoi", {31'b0, intr}, 32'h1);
        rd(4'h8, d); chk("nest_id0", d, 32'h8000_0000);
        ack(); wr(4'hC, 32'h0);
        // random traffic
        for (int n = 0; n < 4000; n++) begin
            Resetn   = ($urandom_range(0, 199) != 0);
            irq      = irq ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
            inta     = ($urandom_range(0, 3) == 0);
            io_sel   = ($urandom_range(0, 1) == 0);
            io_we    = ($urandom_range(0, 3) == 0);
            io_addr  = 4'($urandom);
            io_wdata = $urandom;
            if (io_addr[3:2] == 0) io_wdata[7:0] = 8'($urandom) & 8'($urandom);
            cycle();
        end
        Resetn = 1;
        quiet();
        cycle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
